// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int DEFAULT_NUM_LINES  = 64;
  localparam int DEFAULT_LINE_WORDS = 4;
  localparam int DEFAULT_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REFILL_REQ,
    REFILL_WAIT,
    RESPOND
  } icache_state_t;

  // Word-offset field width inside a line.
  function automatic int offset_width(input int line_words);
    return $clog2(line_words);
  endfunction

  // Line-index field width.
  function automatic int index_width(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Tag width: everything above index, offset and the two byte bits.
  function automatic int tag_width(input int addr_width, input int num_lines,
                                   input int line_words);
    return addr_width - $clog2(num_lines) - $clog2(line_words) - 2;
  endfunction

endpackage

// File: rtl/icache_tag_array.sv
// Valid-bit and tag storage for the instruction cache.
// Lookup is combinational; writes are synchronous; clear invalidates every
// line in a single cycle.
module icache_tag_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = DEFAULT_NUM_LINES,
  parameter int INDEX_W   = index_width(DEFAULT_NUM_LINES),
  parameter int TAG_W     = tag_width(DEFAULT_ADDR_WIDTH, DEFAULT_NUM_LINES,
                                      DEFAULT_LINE_WORDS)
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_hit,
  input  logic               write_en,
  input  logic [INDEX_W-1:0] write_index,
  input  logic [TAG_W-1:0]   write_tag,
  input  logic               write_valid,
  input  logic               clear
);

  logic [NUM_LINES-1:0] valid_bits;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];

  // Valid bits: reset and clear wipe every line, a refill sets or leaves one.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear) begin
      valid_bits <= '0;
    end else if (write_en) begin
      valid_bits[write_index] <= write_valid;
    end
  end

  // Tag storage needs no reset because the valid bits gate every lookup.
  always_ff @(posedge i_Clock) begin
    if (write_en) begin
      tag_mem[write_index] <= write_tag;
    end
  end

  assign lookup_hit = valid_bits[lookup_index] &&
                      (tag_mem[lookup_index] == lookup_tag);

endmodule

// File: rtl/instruction_cache_dm.sv
// Direct-mapped instruction cache between fetch and the memory bus.
// Hits answer one cycle after the request; misses refill a whole line with
// a burst and then return the requested word. i_Flush invalidates all lines.
// Optional hit/miss counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module instruction_cache_dm
  import icache_pkg::*;
#(
  parameter int NUM_LINES  = DEFAULT_NUM_LINES,
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_ReqValid,
  input  logic [ADDR_WIDTH-1:0] i_Address,
  output logic                  o_ReqReady,
  output logic                  o_DataValid,
  output logic [31:0]           o_DataOut,
  output logic                  o_AddressMisaligned,
  input  logic                  i_Flush,
  output logic                  o_MemReqValid,
  output logic [ADDR_WIDTH-1:0] o_MemAddress,
  input  logic                  i_MemReqReady,
  input  logic                  i_MemDataValid,
  input  logic [31:0]           i_MemData,
  output logic [31:0]           o_HitCount,
  output logic [31:0]           o_MissCount
);

  localparam int OFFSET_W = offset_width(LINE_WORDS);
  localparam int INDEX_W  = index_width(NUM_LINES);
  localparam int TAG_W    = tag_width(ADDR_WIDTH, NUM_LINES, LINE_WORDS);
  localparam int LINE_LSB = OFFSET_W + 2;
  localparam int DEPTH    = NUM_LINES * LINE_WORDS;
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  icache_state_t state;

  logic [OFFSET_W-1:0] req_offset;
  logic [INDEX_W-1:0]  req_index;
  logic [TAG_W-1:0]    req_tag;

  logic [OFFSET_W-1:0] miss_offset;
  logic [INDEX_W-1:0]  miss_index;
  logic [TAG_W-1:0]    miss_tag;
  logic [OFFSET_W-1:0] beat_count;
  logic [31:0]         captured_word;
  logic                flush_pending;

  logic lookup_hit;
  logic accept;
  logic hit_accept;
  logic miss_accept;
  logic beat_write;
  logic last_beat;
  logic tag_write_valid;
  logic tag_clear;

  logic [31:0] data_mem [DEPTH];

  assign req_offset = i_Address[LINE_LSB-1:2];
  assign req_index  = i_Address[LINE_LSB +: INDEX_W];
  assign req_tag    = i_Address[ADDR_WIDTH-1 -: TAG_W];

  assign o_AddressMisaligned = |i_Address[1:0];
  assign o_ReqReady          = (state == IDLE);

  // A flush in IDLE wins over a request arriving in the same cycle.
  assign accept      = (state == IDLE) && i_ReqValid && !i_Flush;
  assign hit_accept  = accept && !o_AddressMisaligned && lookup_hit;
  assign miss_accept = accept && !o_AddressMisaligned && !lookup_hit;

  assign beat_write = (state == REFILL_WAIT) && i_MemDataValid;
  assign last_beat  = beat_write && (beat_count == LAST_BEAT);

  // A flush seen at any point of the refill keeps the new line invalid.
  assign tag_write_valid = !(flush_pending || i_Flush);

  // Invalidate immediately in IDLE, or on the way back to IDLE after a
  // refill that saw a flush.
  assign tag_clear = ((state == IDLE) && i_Flush) ||
                     ((state == RESPOND) && (flush_pending || i_Flush));

  icache_tag_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_tag_array (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .lookup_index (req_index),
    .lookup_tag   (req_tag),
    .lookup_hit   (lookup_hit),
    .write_en     (last_beat),
    .write_index  (miss_index),
    .write_tag    (miss_tag),
    .write_valid  (tag_write_valid),
    .clear        (tag_clear)
  );

  // Refill beats land in the data array at consecutive word offsets.
  always_ff @(posedge i_Clock) begin
    if (beat_write) begin
      data_mem[{miss_index, beat_count}] <= i_MemData;
    end
  end

  // Cache controller with registered outputs.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state         <= IDLE;
      o_DataValid   <= 1'b0;
      o_DataOut     <= '0;
      o_MemReqValid <= 1'b0;
      o_MemAddress  <= '0;
      miss_offset   <= '0;
      miss_index    <= '0;
      miss_tag      <= '0;
      beat_count    <= '0;
      captured_word <= '0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          o_DataValid <= 1'b0;
          if (hit_accept) begin
            o_DataValid <= 1'b1;
            o_DataOut   <= data_mem[{req_index, req_offset}];
          end else if (miss_accept) begin
            miss_offset   <= req_offset;
            miss_index    <= req_index;
            miss_tag      <= req_tag;
            beat_count    <= '0;
            flush_pending <= 1'b0;
            o_MemReqValid <= 1'b1;
            o_MemAddress  <= {req_tag, req_index, {LINE_LSB{1'b0}}};
            state         <= REFILL_REQ;
          end
        end

        REFILL_REQ: begin
          flush_pending <= flush_pending | i_Flush;
          if (i_MemReqReady) begin
            o_MemReqValid <= 1'b0;
            state         <= REFILL_WAIT;
          end
        end

        REFILL_WAIT: begin
          flush_pending <= flush_pending | i_Flush;
          if (i_MemDataValid) begin
            beat_count <= beat_count + 1'b1;
            if (beat_count == miss_offset) begin
              captured_word <= i_MemData;
            end
            if (beat_count == LAST_BEAT) begin
              o_DataValid <= 1'b1;
              o_DataOut   <= (beat_count == miss_offset) ? i_MemData
                                                         : captured_word;
              state       <= RESPOND;
            end
          end
        end

        RESPOND: begin
          o_DataValid   <= 1'b0;
          flush_pending <= 1'b0;
          state         <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  // Wrapping counters of accepted aligned hits and misses; flush leaves them.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_accept) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_accept) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end

  assign o_HitCount  = hit_count;
  assign o_MissCount = miss_count;
`else
  assign o_HitCount  = '0;
  assign o_MissCount = '0;
`endif

endmodule

// File: tb/tb_instruction_cache_dm.sv
// Directed self-checking bench for instruction_cache_dm (64 lines x 4 words).
// Counter expectations follow ICACHE_PERF_COUNTERS_EN when it is defined.
module tb_instruction_cache_dm;

`ifdef ICACHE_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_ReqValid = 1'b0;
  logic [31:0] i_Address = '0;
  logic        o_ReqReady;
  logic        o_DataValid;
  logic [31:0] o_DataOut;
  logic        o_AddressMisaligned;
  logic        i_Flush = 1'b0;
  logic        o_MemReqValid;
  logic [31:0] o_MemAddress;
  logic        i_MemReqReady = 1'b0;
  logic        i_MemDataValid = 1'b0;
  logic [31:0] i_MemData = '0;
  logic [31:0] o_HitCount;
  logic [31:0] o_MissCount;

  int checks = 0;
  int passed = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  instruction_cache_dm #(
    .NUM_LINES  (64),
    .LINE_WORDS (4),
    .ADDR_WIDTH (32)
  ) dut (
    .i_Clock             (i_Clock),
    .i_Reset             (i_Reset),
    .i_ReqValid          (i_ReqValid),
    .i_Address           (i_Address),
    .o_ReqReady          (o_ReqReady),
    .o_DataValid         (o_DataValid),
    .o_DataOut           (o_DataOut),
    .o_AddressMisaligned (o_AddressMisaligned),
    .i_Flush             (i_Flush),
    .o_MemReqValid       (o_MemReqValid),
    .o_MemAddress        (o_MemAddress),
    .i_MemReqReady       (i_MemReqReady),
    .i_MemDataValid      (i_MemDataValid),
    .i_MemData           (i_MemData),
    .o_HitCount          (o_HitCount),
    .o_MissCount         (o_MissCount)
  );

  always #5 i_Clock = ~i_Clock;

  // Backing memory contents: every word is distinct and derived from its address.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return 32'hC0DE_0000 ^ addr;
  endfunction

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hits"}, o_HitCount, PERF ? 32'(exp_hits) : 32'd0);
    checkOutput({tag, "_misses"}, o_MissCount, PERF ? 32'(exp_misses) : 32'd0);
  endtask

  // One-cycle fetch request; outputs are sampled just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] addr);
    i_ReqValid = 1'b1;
    i_Address  = addr;
    tick();
    i_ReqValid = 1'b0;
  endtask

  // Memory side of a refill: optional handshake stall, optional gaps between
  // beats, optional flush pulse alongside one beat.
  task automatic serveRefill(input logic [31:0] line, input int hold,
                             input int gap, input int flush_beat);
    int waited = 0;
    while (!o_MemReqValid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("mem_req_valid", 32'(o_MemReqValid), 32'd1);
    checkOutput("mem_address", o_MemAddress, line);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_req_valid", 32'(o_MemReqValid), 32'd1);
      checkOutput("hold_address", o_MemAddress, line);
      checkOutput("hold_req_ready", 32'(o_ReqReady), 32'd0);
    end
    i_MemReqReady = 1'b1;
    tick();
    i_MemReqReady = 1'b0;
    checkOutput("mem_req_dropped", 32'(o_MemReqValid), 32'd0);
    for (int b = 0; b < 4; b++) begin
      repeat (gap) tick();
      i_MemDataValid = 1'b1;
      i_MemData      = memWord(line + 32'(4 * b));
      i_Flush        = (b == flush_beat);
      tick();
      i_MemDataValid = 1'b0;
      i_Flush        = 1'b0;
      i_MemData      = '0;
    end
  endtask

  // Checks the response cycle of a refill and the return to IDLE after it.
  task automatic checkRefillResponse(input string tag, input logic [31:0] addr);
    checkOutput({tag, "_valid"}, 32'(o_DataValid), 32'd1);
    checkOutput({tag, "_data"}, o_DataOut, memWord(addr));
    tick();
    checkOutput({tag, "_pulse_end"}, 32'(o_DataValid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(o_ReqReady), 32'd1);
  endtask

  task automatic checkHit(input string tag, input logic [31:0] addr);
    applyStimulus(addr);
    exp_hits++;
    checkOutput({tag, "_valid"}, 32'(o_DataValid), 32'd1);
    checkOutput({tag, "_data"}, o_DataOut, memWord(addr));
    checkOutput({tag, "_no_refill"}, 32'(o_MemReqValid), 32'd0);
  endtask

  task automatic checkMiss(input string tag, input logic [31:0] addr);
    applyStimulus(addr);
    exp_misses++;
    checkOutput({tag, "_valid"}, 32'(o_DataValid), 32'd0);
    checkOutput({tag, "_ready"}, 32'(o_ReqReady), 32'd0);
    checkOutput({tag, "_refill"}, 32'(o_MemReqValid), 32'd1);
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    repeat (2) tick();
    i_Reset = 1'b0;
    tick();
    checkOutput("rst_data_valid", 32'(o_DataValid), 32'd0);
    checkOutput("rst_data_out", o_DataOut, 32'd0);
    checkOutput("rst_mem_req", 32'(o_MemReqValid), 32'd0);
    checkOutput("rst_mem_addr", o_MemAddress, 32'd0);
    checkOutput("rst_ready", 32'(o_ReqReady), 32'd1);
    checkCounters("rst");

    // Cold miss on 0x104, then hit on 0x108 in the same line
    i_Address = 32'h104;
    #1;
    checkOutput("aligned_flag", 32'(o_AddressMisaligned), 32'd0);
    checkMiss("cold", 32'h104);
    serveRefill(32'h100, 0, 0, -1);
    checkRefillResponse("cold_resp", 32'h104);
    checkHit("hit_108", 32'h108);
    checkHit("hit_100", 32'h100);
    checkCounters("after_cold");

    // Conflict eviction: 0x000 and 0x400 share index 0
    checkMiss("fill_000", 32'h000);
    serveRefill(32'h000, 0, 0, -1);
    checkRefillResponse("fill_000_resp", 32'h000);
    checkHit("hit_00c", 32'h00C);
    checkMiss("conflict_400", 32'h400);
    serveRefill(32'h400, 0, 0, -1);
    checkRefillResponse("conflict_400_resp", 32'h400);
    checkMiss("evicted_000", 32'h000);
    serveRefill(32'h000, 0, 0, -1);
    checkRefillResponse("evicted_000_resp", 32'h000);

    // Misaligned request: flag is combinational, no response, no refill
    i_ReqValid = 1'b1;
    i_Address  = 32'h102;
    #1;
    checkOutput("misaligned_flag", 32'(o_AddressMisaligned), 32'd1);
    tick();
    i_ReqValid = 1'b0;
    checkOutput("misaligned_valid", 32'(o_DataValid), 32'd0);
    checkOutput("misaligned_refill", 32'(o_MemReqValid), 32'd0);
    checkOutput("misaligned_ready", 32'(o_ReqReady), 32'd1);
    checkCounters("misaligned");

    // Backpressure: 5 stalled handshake cycles, gapped beats, last-word request
    checkMiss("bp_20c", 32'h20C);
    serveRefill(32'h200, 5, 2, -1);
    checkRefillResponse("bp_resp", 32'h20C);
    checkHit("bp_hit_204", 32'h204);

    // Flush in IDLE beats a same-cycle request, then 0x100 misses
    checkHit("pre_flush_100", 32'h100);
    i_Flush = 1'b1;
    applyStimulus(32'h104);
    i_Flush = 1'b0;
    checkOutput("flush_req_valid", 32'(o_DataValid), 32'd0);
    checkOutput("flush_req_refill", 32'(o_MemReqValid), 32'd0);
    checkOutput("flush_ready", 32'(o_ReqReady), 32'd1);
    checkMiss("post_flush_100", 32'h100);
    serveRefill(32'h100, 0, 0, -1);
    checkRefillResponse("post_flush_resp", 32'h100);

    // Flush during refill: word still returned, line left invalid
    checkMiss("flush_mid_300", 32'h308);
    serveRefill(32'h300, 0, 1, 1);
    checkRefillResponse("flush_mid_resp", 32'h308);
    checkMiss("flush_mid_again", 32'h300);
    serveRefill(32'h300, 0, 0, -1);
    checkRefillResponse("flush_mid_again_resp", 32'h300);
    checkMiss("flush_mid_100_gone", 32'h100);
    serveRefill(32'h100, 0, 0, -1);
    checkRefillResponse("flush_mid_100_resp", 32'h100);
    checkHit("hit_30c", 32'h30C);
    checkCounters("after_flush");

    // Reset in the middle of a refill after two beats
    checkMiss("rst_mid_500", 32'h508);
    checkOutput("rst_mid_addr", o_MemAddress, 32'h500);
    i_MemReqReady = 1'b1;
    tick();
    i_MemReqReady = 1'b0;
    for (int b = 0; b < 2; b++) begin
      i_MemDataValid = 1'b1;
      i_MemData      = memWord(32'h500 + 32'(4 * b));
      tick();
    end
    i_MemDataValid = 1'b0;
    i_Reset        = 1'b1;
    tick();
    i_Reset        = 1'b0;
    exp_hits       = 0;
    exp_misses     = 0;
    checkOutput("rst_mid_ready", 32'(o_ReqReady), 32'd1);
    checkOutput("rst_mid_valid", 32'(o_DataValid), 32'd0);
    checkOutput("rst_mid_mem_req", 32'(o_MemReqValid), 32'd0);
    checkOutput("rst_mid_mem_addr", o_MemAddress, 32'd0);
    checkCounters("rst_mid");
    checkMiss("restart_508", 32'h508);
    serveRefill(32'h500, 0, 0, -1);
    checkRefillResponse("restart_resp", 32'h508);
    checkHit("restart_hit_50c", 32'h50C);
    checkMiss("after_rst_300", 32'h300);
    serveRefill(32'h300, 0, 0, -1);
    checkRefillResponse("after_rst_300_resp", 32'h300);
    checkCounters("final");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
